videocard_host_ctrl: RTL and testbench

//  Host-side controller for the videocard: the initiator of its kick/finish protocol.

---
 rtl/videocard_host_ctrl_if.sv | 42 ++++
 rtl/videocard_host_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_videocard_host_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/videocard_host_ctrl_if.sv
// Host-controller bus bundle: program stream in, ROM write port out, core kick/finish, status.
// Purely wiring; every output the controller drives through it is registered inside the controller.
// prog_valid/prog_ready handshake is the only backpressure path; all other strobes are unconditioned.
//  master : controller side (drives ROM port, core control and status)
//  slave  : environment side (drives program words, launch/abort, interrupt_finish)
interface videocard_host_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int CORE_NUM = 4
);
    logic                 prog_valid;
    logic                 prog_ready;
    logic [WIDTH-1:0]     prog_data;
    logic                 prog_last;
    logic [WIDTH/2-1:0]   load_base;
    logic                 launch;
    logic [CORE_NUM-1:0]  launch_mask;
    logic                 abort;
    logic [WIDTH/2-1:0]   address_rom;
    logic [WIDTH-1:0]     data_in_rom;
    logic                 wren_rom;
    logic [CORE_NUM-1:0]  core_en;
    logic                 interrupt_start;
    logic                 interrupt_finish;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic [WIDTH-1:0]     cycle_count;

    modport master (
        input  prog_valid, prog_data, prog_last, load_base,
        input  launch, launch_mask, abort, interrupt_finish,
        output prog_ready, address_rom, data_in_rom, wren_rom,
        output core_en, interrupt_start, busy, done, timeout, cycle_count
    );

    modport slave (
        output prog_valid, prog_data, prog_last, load_base,
        output launch, launch_mask, abort, interrupt_finish,
        input  prog_ready, address_rom, data_in_rom, wren_rom,
        input  core_en, interrupt_start, busy, done, timeout, cycle_count
    );
endinterface

// File: rtl/videocard_host_ctrl.sv
// Host controller: loads a program into the shared instruction ROM, then kicks selected cores and waits for finish.
// Latency: ROM write 1 cycle after word acceptance; interrupt_start 1 cycle after launch; done 1 cycle after finish edge.
// Backpressure: prog_ready is high only in IDLE/LOAD; launch is dropped outside IDLE; abort overrides everything.
//  clk, reset (async, active-high) plain ports; all other signals through videocard_host_ctrl_if.master:
//  program stream (prog_*, load_base), launch/launch_mask/abort, ROM write port (address_rom, data_in_rom,
//  wren_rom), core control (core_en, interrupt_start, interrupt_finish), status (busy, done, timeout, cycle_count).
module videocard_host_ctrl #(
    parameter int WIDTH          = 32,
    parameter int CORE_NUM       = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic                   clk,
    input logic                   reset,
    videocard_host_ctrl_if.master bus
);
    localparam int AW = WIDTH / 2;
    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int TW = 32;
    localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
    // Only meaningful when the timeout is enabled.
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;        // doubles as the ROM write pointer
    logic [WIDTH-1:0]    data_q, data_d;
    logic                wren_q, wren_d;
    logic                prog_ready_q, prog_ready_d;
    logic [CORE_NUM-1:0] core_en_q, core_en_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [SW-1:0]       start_cnt_q, start_cnt_d;
    logic [TW-1:0]       run_cnt_q, run_cnt_d;
    logic                fin_prev_q;

    logic             accept;
    logic             fin_edge;
    logic [WIDTH-1:0] count_inc;

    assign accept    = bus.prog_valid & prog_ready_q;
    assign fin_edge  = bus.interrupt_finish & ~fin_prev_q;
    assign count_inc = (count_q == '1) ? count_q : count_q + WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        core_en_d   = core_en_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        count_d     = count_q;
        start_cnt_d = start_cnt_q;
        run_cnt_d   = run_cnt_q;

        if (bus.abort) begin
            // Leaves ROM contents and cycle_count as they are; no completion pulses.
            state_d   = ST_IDLE;
            core_en_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A first program word takes precedence over a simultaneous launch.
                    if (accept) begin
                        addr_d  = bus.load_base;
                        data_d  = bus.prog_data;
                        wren_d  = 1'b1;
                        state_d = bus.prog_last ? ST_IDLE : ST_LOAD;
                    end else if (bus.launch) begin
                        count_d = '0;
                        if (bus.launch_mask == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = ST_START;
                            core_en_d   = bus.launch_mask;
                            start_d     = 1'b1;
                            start_cnt_d = '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        addr_d  = addr_q + AW'(1);
                        data_d  = bus.prog_data;
                        wren_d  = 1'b1;
                        state_d = bus.prog_last ? ST_IDLE : ST_LOAD;
                    end
                end
                ST_START: begin
                    count_d = count_inc;
                    if (start_cnt_q == START_LAST) begin
                        state_d   = ST_RUN;
                        run_cnt_d = '0;
                    end else begin
                        start_cnt_d = start_cnt_q + SW'(1);
                        start_d     = 1'b1;
                    end
                end
                ST_RUN: begin
                    // The terminating cycle does not add to cycle_count, so it reads
                    // the distance from the first START cycle to the finish cycle.
                    if (fin_edge) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        core_en_d = '0;
                    end else if ((TIMEOUT_CYCLES != 0) && (run_cnt_q == TO_LAST)) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        core_en_d = '0;
                    end else begin
                        count_d   = count_inc;
                        run_cnt_d = run_cnt_q + TW'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    core_en_d = '0;
                end
            endcase
        end

        busy_d       = (state_d != ST_IDLE);
        prog_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
            prog_ready_q <= 1'b1;
            core_en_q    <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            start_cnt_q  <= '0;
            run_cnt_q    <= '0;
            fin_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            prog_ready_q <= prog_ready_d;
            core_en_q    <= core_en_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
            start_cnt_q  <= start_cnt_d;
            run_cnt_q    <= run_cnt_d;
            fin_prev_q   <= bus.interrupt_finish;
        end
    end

    assign bus.prog_ready      = prog_ready_q;
    assign bus.address_rom     = addr_q;
    assign bus.data_in_rom     = data_q;
    assign bus.wren_rom        = wren_q;
    assign bus.core_en         = core_en_q;
    assign bus.interrupt_start = start_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.timeout         = timeout_q;
    assign bus.cycle_count     = count_q;
endmodule

// File: tb/tb_videocard_host_ctrl.sv
// Bench for the videocard host controller: directed scenarios plus randomized load/run operations.
// Expected ROM writes, done and timeout pulses are queued with their cycle of arrival; a negedge monitor pops them.
// Level outputs (core_en, interrupt_start, busy, prog_ready) are checked every cycle against expected windows.
module tb_videocard_host_ctrl;
    localparam int START_C = 2;
    localparam int TO_C    = 100;
    localparam int BIG     = 32'h3fff_ffff;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    bit   mon_en;

    videocard_host_ctrl_if #(.WIDTH(32), .CORE_NUM(4)) bus ();

    videocard_host_ctrl #(
        .WIDTH(32), .CORE_NUM(4), .START_CYCLES(START_C), .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int c; logic [15:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int c; logic [31:0] cnt; } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    to_q[$];
    wr_t   mw;
    done_t md;

    // Expected windows (inclusive cycle ranges) for level outputs.
    int st_lo = 0, st_hi = -1;
    int en_lo = 0, en_hi = -1;
    logic [3:0] en_val = 4'd0;
    int bz_lo = 0, bz_hi = -1;
    int nr_lo = 0, nr_hi = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic bit inwin(input int lo, input int hi);
        return (cyc >= lo) && (cyc <= hi);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_q.size() != 0 && wr_q[0].c == cyc) begin
                mw = wr_q.pop_front();
                chk("wren_rom", 64'(bus.wren_rom), 64'(1));
                chk("address_rom", 64'(bus.address_rom), 64'(mw.addr));
                chk("data_in_rom", 64'(bus.data_in_rom), 64'(mw.data));
            end else begin
                chk("wren_rom_idle", 64'(bus.wren_rom), 64'(0));
            end
            if (done_q.size() != 0 && done_q[0].c == cyc) begin
                md = done_q.pop_front();
                chk("done", 64'(bus.done), 64'(1));
                chk("done_cycle_count", 64'(bus.cycle_count), 64'(md.cnt));
            end else begin
                chk("done_idle", 64'(bus.done), 64'(0));
            end
            if (to_q.size() != 0 && to_q[0] == cyc) begin
                void'(to_q.pop_front());
                chk("timeout", 64'(bus.timeout), 64'(1));
            end else begin
                chk("timeout_idle", 64'(bus.timeout), 64'(0));
            end
            chk("strobe_exclusive", 64'($onehot0({bus.wren_rom, bus.done, bus.timeout})), 64'(1));
            chk("interrupt_start", 64'(bus.interrupt_start), 64'(inwin(st_lo, st_hi)));
            chk("core_en", 64'(bus.core_en), 64'(inwin(en_lo, en_hi) ? en_val : 4'd0));
            chk("busy", 64'(bus.busy), 64'(inwin(bz_lo, bz_hi)));
            chk("prog_ready", 64'(bus.prog_ready), 64'(!inwin(nr_lo, nr_hi)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.prog_valid  = 1'b0;
        bus.prog_last   = 1'b0;
        bus.launch      = 1'b0;
        bus.launch_mask = 4'd0;
        bus.abort       = 1'b0;
    endtask

    // Streams n words from base; abort_at / launch_at give the word index that carries abort / launch (-1: none).
    task automatic load_prog(input logic [15:0] base, input int n, input int gap_max,
                             input int abort_at, input int launch_at);
        logic [15:0] a;
        logic [31:0] w;
        a = base;
        for (int i = 0; i < n; i++) begin
            if (i != 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                for (int j = 0; j < g; j++) begin tick(); clear(); end
            end
            tick(); clear();
            w = $urandom;
            bus.prog_valid = 1'b1;
            bus.prog_data  = w;
            bus.prog_last  = (i == n - 1);
            bus.load_base  = (i == 0) ? base : 16'($urandom);
            chk("prog_ready_at_word", 64'(bus.prog_ready), 64'(1));
            if (i == 0) begin bz_lo = cyc + 1; bz_hi = BIG; end
            if (i == launch_at) begin
                bus.launch      = 1'b1;
                bus.launch_mask = 4'($urandom_range(15, 1));
            end
            if (i == abort_at) begin
                bus.abort = 1'b1;
                bz_hi = cyc;
                break;
            end
            wr_q.push_back('{cyc + 1, a, w});
            a = a + 16'd1;
            if (i == n - 1) bz_hi = cyc;
        end
        tick(); clear();
    endtask

    // mode 0: finish rises d cycles after RUN entry; 1: finish already high before launch;
    // 2: finish rises during START. abort_after >= 0 aborts that many cycles after the first START cycle.
    task automatic do_run(input logic [3:0] mask, input int mode, input int d, input int abort_after);
        int L, R, f, term, a_cyc;
        logic [31:0] exp_cnt;
        bit cnt_chk;
        tick(); clear();
        if (mode == 1) bus.interrupt_finish = 1'b1;
        tick(); clear();
        bus.launch      = 1'b1;
        bus.launch_mask = mask;
        L = cyc;
        if (mask == 4'd0) begin
            done_q.push_back('{L + 1, 32'd0});
            tick(); clear();
            tick(); clear();
            chk("count_after_mask0", 64'(bus.cycle_count), 64'(0));
            bus.interrupt_finish = 1'b0;
            return;
        end
        R = L + START_C + 1;
        st_lo = L + 1; st_hi = L + START_C;
        en_lo = L + 1; en_val = mask;
        bz_lo = L + 1; nr_lo = L + 1;
        if (mode == 0 && d < TO_C) begin
            term = R + d; en_hi = term; bz_hi = term + 1;
        end else begin
            term = R + TO_C - 1; en_hi = term; bz_hi = term;
        end
        if (mode == 0) f = R + d;
        else if (mode == 1) f = L - 1;
        else f = L + 1 + $urandom_range(START_C - 1, 0);
        a_cyc = (abort_after >= 0) ? L + 1 + abort_after : -1;
        cnt_chk = 1'b1;
        if (a_cyc >= 0 && a_cyc <= term) begin
            en_hi = a_cyc; bz_hi = a_cyc;
            if (st_hi > a_cyc) st_hi = a_cyc;
            exp_cnt = 32'(a_cyc - (L + 1));
        end else if (mode == 0 && d < TO_C) begin
            exp_cnt = 32'(term - (L + 1));
            done_q.push_back('{term + 1, exp_cnt});
        end else begin
            to_q.push_back(term + 1);
            exp_cnt = 32'd0;
            cnt_chk = 1'b0;
        end
        nr_hi = bz_hi;
        while (cyc < term + 2) begin
            tick(); clear();
            if (mode != 1) bus.interrupt_finish = (cyc >= f);
            if (cyc == a_cyc) bus.abort = 1'b1;
        end
        bus.interrupt_finish = 1'b0;
        tick(); clear();
        if (cnt_chk) chk("cycle_count_hold", 64'(bus.cycle_count), 64'(exp_cnt));
    endtask

    task automatic reset_mid_run();
        int L;
        tick(); clear();
        bus.launch      = 1'b1;
        bus.launch_mask = 4'b1011;
        L = cyc;
        st_lo = L + 1; st_hi = L + START_C;
        en_lo = L + 1; en_hi = BIG; en_val = 4'b1011;
        bz_lo = L + 1; bz_hi = BIG;
        nr_lo = L + 1; nr_hi = BIG;
        repeat (10) begin tick(); clear(); end
        chk("core_en_before_reset", 64'(bus.core_en), 64'(4'b1011));
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_core_en", 64'(bus.core_en), 64'(0));
        chk("rst_interrupt_start", 64'(bus.interrupt_start), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_prog_ready", 64'(bus.prog_ready), 64'(1));
        chk("rst_cycle_count", 64'(bus.cycle_count), 64'(0));
        tick();
        reset = 1'b0;
        en_hi = cyc; bz_hi = cyc; nr_hi = cyc; st_hi = cyc;
        tick();
        mon_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        bus.prog_data        = 32'd0;
        bus.load_base        = 16'd0;
        bus.interrupt_finish = 1'b0;
        clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_prog_ready", 64'(bus.prog_ready), 64'(1));
        chk("reset_wren_rom", 64'(bus.wren_rom), 64'(0));
        chk("reset_address_rom", 64'(bus.address_rom), 64'(0));
        chk("reset_data_in_rom", 64'(bus.data_in_rom), 64'(0));
        chk("reset_core_en", 64'(bus.core_en), 64'(0));
        chk("reset_interrupt_start", 64'(bus.interrupt_start), 64'(0));
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_timeout", 64'(bus.timeout), 64'(0));
        chk("reset_cycle_count", 64'(bus.cycle_count), 64'(0));
        reset = 1'b0;
        tick();
        mon_en = 1'b1;

        // Back-to-back load, then a load that wraps the ROM pointer.
        load_prog(16'h0010, 4, 0, -1, -1);
        load_prog(16'hFFFE, 3, 0, -1, -1);

        // Completion 50 cycles into RUN.
        do_run(4'b0101, 0, 50, -1);
        chk("tc3_cycle_count", 64'(bus.cycle_count), 64'(52));

        // finish already high: never re-rises, so the run times out.
        do_run(4'b1100, 1, 0, -1);
        // Finish edge on the very cycle the timeout would fire: completion wins.
        do_run(4'b0011, 0, TO_C - 1, -1);
        // Edge at RUN entry completes; edge during START does not.
        do_run(4'b1111, 0, 0, -1);
        do_run(4'b0110, 2, 0, -1);

        // Abort mid-load (with a word offered in the abort cycle), mid-START and mid-RUN.
        load_prog(16'h1234, 6, 1, 3, -1);
        do_run(4'b1001, 0, 60, 1);
        do_run(4'b1001, 0, 60, 20);
        reset_mid_run();

        // Empty mask, launch during LOAD, launch alongside the first word.
        do_run(4'b0000, 0, 0, -1);
        load_prog(16'h0200, 5, 1, -1, 2);
        load_prog(16'h0300, 3, 0, -1, 0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                load_prog(16'($urandom), $urandom_range(8, 1), $urandom_range(2, 0),
                          ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 1)) : -1,
                          ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1);
            end else begin
                int md_sel, dd, ab;
                md_sel = $urandom_range(5, 0);
                if (md_sel > 2) md_sel = 0;
                dd = $urandom_range(110, 0);
                ab = ($urandom_range(4, 0) == 0) ? int'($urandom_range(60, 0)) : -1;
                do_run(4'($urandom_range(15, 0)), md_sel, dd, ab);
            end
        end

        repeat (4) tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
